// File: rtl/lsu_pkg.sv
// Shared constants for the load/store alignment unit: RV32I width codes, byte enables, FSM states.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  localparam int WAIT_MAX_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_load_fmt.sv
// Load lane extraction and sign/zero extension; purely combinational, no backpressure.
// Undefined width codes return the whole word.
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr, 3'b000} +: 8];
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{lane_b[7]}}, lane_b};
      LH:      data = {{16{lane_h[15]}}, lane_h};
      LBU:     data = {24'h0, lane_b};
      LHU:     data = {16'h0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// RV32I load/store alignment to a word memory port; 2+wait cycles accept-to-response, one request in flight.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W requests skip memory and respond with rsp_misalign.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        rsp_misalign,
`endif
  output logic        rsp_err
);

  localparam logic [31:0] WAIT_LIM = 32'(WAIT_MAX);

  state_t      state, state_n;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic [31:0] cnt;
  logic        err_r;
  logic        wait_hit;
  logic        trap;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] fmt_data;

  // Store lanes: narrow data is replicated so the enabled lane always carries it.
  always_comb begin
    st_be    = BE_W;
    st_wdata = req_wdata;
    case (req_funct3)
      LB, LBU: begin
        st_be    = BE_B << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      LH, LHU: begin
        st_be    = req_addr[1] ? BE_H_HI : BE_H_LO;
        st_wdata = {2{req_wdata[15:0]}};
      end
      LW: begin
        st_be    = BE_W;
        st_wdata = req_wdata;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_r;
  always_comb begin
    case (req_funct3)
      LB, LBU: trap = 1'b0;
      LH, LHU: trap = req_addr[0];
      default: trap = (req_addr[1:0] != 2'b00);
    endcase
  end
  assign rsp_misalign = mis_r;
`else
  assign trap = 1'b0;
`endif

  lsu_load_fmt u_fmt (
    .rdata  (mem_rdata),
    .addr   (off_r),
    .funct3 (f3_r),
    .data   (fmt_data)
  );

  assign wait_hit = (cnt + 32'd1) == WAIT_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = trap ? RESP : ACCESS;
      ACCESS:  if (mem_ack || wait_hit) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      off_r   <= 2'b00;
      addr_r  <= 32'h0;
      be_r    <= 4'h0;
      wdata_r <= 32'h0;
      rdata_r <= 32'h0;
      cnt     <= 32'h0;
      err_r   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_r    <= req_we;
          f3_r    <= req_funct3;
          off_r   <= req_addr[1:0];
          addr_r  <= {req_addr[31:2], 2'b00};
          be_r    <= req_we ? st_be : BE_W;
          wdata_r <= st_wdata;
          rdata_r <= 32'h0;
          cnt     <= 32'h0;
          err_r   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_r   <= trap;
`endif
        end
        ACCESS: begin
          if (mem_ack) begin
            rdata_r <= we_r ? 32'h0 : fmt_data;
          end else begin
            cnt <= cnt + 32'd1;
            if (wait_hit) err_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  // Gated with reset so the strobe drops the instant reset asserts.
  assign mem_en    = (state == ACCESS) && rst_n;
  assign mem_we    = we_r;
  assign mem_be    = be_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

endmodule
